// File: rtl/gpu_pkg.sv
// Shared frame-buffer geometry, pixel-index width and fill-sequencer state encoding.
// Used by the fill engine and its port-A arbiter.
package gpu_pkg;

    localparam int X_SIZE_DEF = 480;
    localparam int Y_SIZE_DEF = 800;
    localparam int PIX_W      = 19;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        NEXT_ROW,
        DONE
    } fill_state_e;

    // Two pixels share a word: odd pixel index in [31:16], even in [15:0].
    function automatic logic [3:0] lane_wen(input logic odd_pix, input logic pair);
        if (pair) begin
            return 4'b1111;
        end
        return odd_pix ? 4'b1100 : 4'b0011;
    endfunction

endpackage

// File: rtl/fb_fill_arb.sv
// Port-A arbiter for the frame buffer: the CPU always wins, the fill engine
// only drives the port when the CPU is absent and is told so through grant.
module fb_fill_arb #(
    parameter int FB_AW = 18
) (
    input  logic             cpu_en,
    input  logic [3:0]       cpu_wen,
    input  logic [FB_AW-1:0] cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic             eng_en,
    input  logic [3:0]       eng_wen,
    input  logic [FB_AW-1:0] eng_addr,
    input  logic [31:0]      eng_wdata,
    output logic             ram_en,
    output logic [3:0]       ram_wen,
    output logic [FB_AW-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    output logic             grant
);

    assign grant     = !cpu_en;
    assign ram_en    = cpu_en | eng_en;
    assign ram_wen   = cpu_en ? cpu_wen   : eng_wen;
    assign ram_addr  = cpu_en ? cpu_addr  : eng_addr;
    assign ram_wdata = cpu_en ? cpu_wdata : eng_wdata;

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine writing clipped RGB565 rectangles into frame-buffer port A.
// Define FB_FILL_ABORT_EN to let the abort input terminate a fill early.
module fb_fill_engine
    import gpu_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF,
    parameter int FB_AW  = 18
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [9:0]       cmd_x0,
    input  logic [9:0]       cmd_y0,
    input  logic [9:0]       cmd_w,
    input  logic [9:0]       cmd_h,
    input  logic [15:0]      cmd_color,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic             cpu_en,
    input  logic [3:0]       cpu_wen,
    input  logic [FB_AW-1:0] cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             ram_en,
    output logic [3:0]       ram_wen,
    output logic [FB_AW-1:0] ram_addr,
    output logic [31:0]      ram_wdata
);

    localparam logic [10:0]      XS  = 11'(X_SIZE);
    localparam logic [10:0]      YS  = 11'(Y_SIZE);
    localparam logic [PIX_W-1:0] XSP = PIX_W'(X_SIZE);

    fill_state_e      state_q, state_d;
    logic [9:0]       x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [15:0]      color_q, color_d;
    logic [9:0]       x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
    logic [PIX_W-1:0] row_base_q, row_base_d;
    logic             cmd_ready_q, busy_q, done_q;

    logic             abort_eff, grant, eng_en, pair;
    logic [PIX_W-1:0] pix;
    logic [10:0]      x_step, xsum, ysum;
    logic [3:0]       eng_wen;
    logic [FB_AW-1:0] eng_addr;
    logic [31:0]      eng_wdata;

`ifdef FB_FILL_ABORT_EN
    assign abort_eff = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_eff    = 1'b0;
`endif

    assign pix    = row_base_q + PIX_W'(x_q);
    assign pair   = !pix[0] && ((11'(x_q) + 11'd1) < 11'(xe_q));
    assign x_step = 11'(x_q) + (pair ? 11'd2 : 11'd1);
    assign xsum   = 11'(x0_q) + 11'(w_q);
    assign ysum   = 11'(y0_q) + 11'(h_q);

    // The pending write is withheld in the abort cycle so nothing lands after abort.
    assign eng_en    = (state_q == WRITE) && !abort_eff;
    assign eng_wen   = eng_en ? lane_wen(pix[0], pair) : 4'b0000;
    assign eng_addr  = eng_en ? FB_AW'(pix >> 1) : '0;
    assign eng_wdata = eng_en ? {color_q, color_q} : 32'd0;

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_d        = x_q;
        y_d        = y_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        row_base_d = row_base_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    y0_d    = cmd_y0;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (abort_eff || (w_q == 10'd0) || (h_q == 10'd0) ||
                    (11'(x0_q) >= XS) || (11'(y0_q) >= YS)) begin
                    state_d = DONE;
                end else begin
                    row_base_d = PIX_W'(y0_q) * XSP;
                    x_d        = x0_q;
                    y_d        = y0_q;
                    xe_d       = (xsum > XS) ? XS[9:0] : xsum[9:0];
                    ye_d       = (ysum > YS) ? YS[9:0] : ysum[9:0];
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (abort_eff) begin
                    state_d = DONE;
                end else if (grant) begin
                    x_d = x_step[9:0];
                    if (x_step == 11'(xe_q)) begin
                        state_d = NEXT_ROW;
                    end
                end
            end
            NEXT_ROW: begin
                if (abort_eff) begin
                    state_d = DONE;
                end else begin
                    row_base_d = row_base_q + XSP;
                    y_d        = y_q + 10'd1;
                    x_d        = x0_q;
                    state_d    = ((11'(y_q) + 11'd1) == 11'(ye_q)) ? DONE : WRITE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            xe_q        <= '0;
            ye_q        <= '0;
            row_base_q  <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xe_q        <= xe_d;
            ye_q        <= ye_d;
            row_base_q  <= row_base_d;
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

    fb_fill_arb #(
        .FB_AW(FB_AW)
    ) u_arb (
        .cpu_en   (cpu_en),
        .cpu_wen  (cpu_wen),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .eng_en   (eng_en),
        .eng_wen  (eng_wen),
        .eng_addr (eng_addr),
        .eng_wdata(eng_wdata),
        .ram_en   (ram_en),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .grant    (grant)
    );

endmodule

// File: tb/tb_fb_fill_engine.sv
// Scoreboard bench for fb_fill_engine: a pixel-level model predicts the word writes
// and done timing; a monitor compares whatever the DUT puts on port A.
`timescale 1ns/1ps
module tb_fb_fill_engine;

    localparam int XS = 480;
    localparam int YS = 800;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid, cmd_ready;
    logic [9:0]    cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [15:0]   cmd_color;
    logic          abort, busy, done;
    logic          cpu_en;
    logic [3:0]    cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          ram_en;
    logic [3:0]    ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;

    always #5 clk = ~clk;

    fb_fill_engine dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .abort(abort), .busy(busy), .done(done),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    wen;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    int  cpu_mode = 0;
    bit  chk_after_done = 1'b0;
    wr_t mon_e;
    int  mon_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Pixel-by-pixel model: walk the clipped rectangle, pack neighbours sharing a word.
    task automatic build_exp(input int x0, input int y0, input int w, input int h,
                             input logic [15:0] col, output int nwr, output int rows,
                             output bit degen);
        int  xe, ye, p, word, cur;
        logic [3:0] cw;
        bit  have;
        wr_t t;
        nwr   = 0;
        rows  = 0;
        degen = (w == 0) || (h == 0) || (x0 >= XS) || (y0 >= YS);
        if (degen) return;
        xe = (x0 + w > XS) ? XS : x0 + w;
        ye = (y0 + h > YS) ? YS : y0 + h;
        rows = ye - y0;
        for (int y = y0; y < ye; y++) begin
            have = 1'b0;
            cur  = 0;
            cw   = 4'b0000;
            for (int x = x0; x < xe; x++) begin
                p    = y * XS + x;
                word = p / 2;
                if (have && word == cur) begin
                    cw = cw | ((p % 2 == 1) ? 4'b1100 : 4'b0011);
                end else begin
                    if (have) begin
                        t = '{addr: AW'(cur), wen: cw, data: {col, col}};
                        exp_q.push_back(t);
                        nwr++;
                    end
                    have = 1'b1;
                    cur  = word;
                    cw   = (p % 2 == 1) ? 4'b1100 : 4'b0011;
                end
            end
            t = '{addr: AW'(cur), wen: cw, data: {col, col}};
            exp_q.push_back(t);
            nwr++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ram_en"}, ram_en, 0);
        check({tag, "_ram_wen"}, ram_wen, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input logic [15:0] col, input bit timed, input int abort_after);
        int to, c0, nwr, rows;
        bit degen, cut;
        to = 0;
        @(negedge clk);
        while (!cmd_ready && to < 500) begin
            @(negedge clk);
            to++;
        end
        if (!cmd_ready) begin
            flag("cmd_ready_timeout");
            return;
        end
        c0 = cyc;
        build_exp(x0, y0, w, h, col, nwr, rows, degen);
        cut = 1'b0;
`ifdef FB_FILL_ABORT_EN
        if (abort_after >= 0 && !degen && nwr > abort_after) begin
            cut = 1'b1;
            while (exp_q.size() > abort_after) void'(exp_q.pop_back());
        end
`endif
        if (!timed)     done_q.push_back(-1);
        else if (degen) done_q.push_back(c0 + 2);
        else if (cut)   done_q.push_back(c0 + 3 + abort_after);
        else            done_q.push_back(c0 + 2 + nwr + rows);
        $display("fill (%0d,%0d) %0dx%0d color %h cpu_mode %0d abort_after %0d: %0d writes expected",
                 x0, y0, w, h, col, cpu_mode, abort_after, exp_q.size());
        cmd_x0    = 10'(x0);
        cmd_y0    = 10'(y0);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = col;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x0    = 10'($urandom);
        cmd_y0    = 10'($urandom);
        cmd_w     = 10'($urandom);
        cmd_h     = 10'($urandom);
        cmd_color = 16'($urandom);
        if (abort_after >= 0) begin
            repeat (abort_after + 1) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
        end
        to = 0;
        while (done_q.size() != 0 && to < 5000) begin
            @(negedge clk);
            to++;
        end
        if (done_q.size() != 0) begin
            flag("fill_done_timeout");
            exp_q.delete();
            done_q.delete();
        end
    endtask

    // CPU traffic: off, alternating writes to 0x00100, or random bursts.
    initial begin
        cpu_en    = 1'b0;
        cpu_wen   = 4'b0000;
        cpu_addr  = '0;
        cpu_wdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            cpu_wdata = $urandom;
            cpu_wen   = 4'($urandom);
            cpu_addr  = AW'($urandom);
            case (cpu_mode)
                1: begin
                    cpu_en   = !cpu_en;
                    cpu_addr = 18'h00100;
                    cpu_wen  = 4'b1111;
                end
                2:       cpu_en = ($urandom_range(0, 3) == 0);
                default: cpu_en = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (chk_after_done) begin
                check("ready_after_done", {cmd_ready, busy, done}, 3'b100);
                chk_after_done = 1'b0;
            end
            if (cpu_en) begin
                check("cpu_passthrough", {ram_en, ram_wen, ram_addr, ram_wdata},
                      {1'b1, cpu_wen, cpu_addr, cpu_wdata});
            end else if (ram_en) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_write");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("engine_write", {ram_wen, ram_addr, ram_wdata},
                          {mon_e.wen, mon_e.addr, mon_e.data});
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    flag("spurious_done");
                end else begin
                    mon_d = done_q.pop_front();
                    check("busy_in_done", {busy, cmd_ready}, 2'b10);
                    check("writes_complete", exp_q.size(), 0);
                    if (mon_d >= 0) check("done_cycle", cyc, mon_d);
                    chk_after_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, y0, w, h, to;
        bit contended;
        int nwr, rows;
        bit degen;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rstn = 1'b1;

        run_fill(1, 0, 4, 1, 16'hF800, 1, -1);
        run_fill(470, 798, 20, 5, 16'h1234, 1, -1);
        run_fill(0, 5, 0, 3, 16'hFFFF, 1, -1);
        run_fill(480, 5, 4, 3, 16'hABCD, 1, -1);
        run_fill(0, 0, 100, 1, 16'h07E0, 1, 5);

        cpu_mode = 1;
        run_fill(3, 10, 8, 2, 16'h001F, 0, -1);
        cpu_mode = 0;

        for (int i = 0; i < 30; i++) begin
            contended = ($urandom_range(0, 3) == 0);
            cpu_mode  = contended ? 2 : 0;
            x0 = $urandom_range(0, 500);
            y0 = $urandom_range(0, 805);
            w  = $urandom_range(0, 40);
            h  = $urandom_range(0, 5);
            if (i % 4 == 0) begin
                x0 = $urandom_range(440, 479);
                y0 = $urandom_range(790, 799);
            end
            run_fill(x0, y0, w, h, 16'($urandom), !contended, -1);
        end
        cpu_mode = 0;

        // Reset in the middle of a long fill: partial writes stand, engine returns to idle.
        @(negedge clk);
        to = 0;
        while (!cmd_ready && to < 500) begin
            @(negedge clk);
            to++;
        end
        build_exp(0, 0, 200, 4, 16'h5A5A, nwr, rows, degen);
        done_q.push_back(-1);
        $display("fill (0,0) 200x4 color 5a5a: reset after 20 cycles");
        cmd_x0    = 10'd0;
        cmd_y0    = 10'd0;
        cmd_w     = 10'd200;
        cmd_h     = 10'd4;
        cmd_color = 16'h5A5A;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rstn = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1 check_reset_state("midreset");
        @(negedge clk);
        rstn = 1'b1;

        run_fill(2, 2, 6, 3, 16'hC0DE, 1, -1);

        check("final_exp_queue_empty", exp_q.size(), 0);
        check("final_done_queue_empty", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
